// File: rtl/l1_cache_pkg.sv
// Shared types for the LC-3b L1 cache: the CPU word type, the controller
// state encoding and helpers that derive address-field widths from the
// cache geometry.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
endpackage

package cache_types;
    typedef lc3b_types::lc3b_word lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } cache_state_t;

    localparam int ADDR_W = 16;

    // Byte-offset width inside a line.
    function automatic int offset_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Set-index width.
    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: whatever address bits remain above index and offset.
    function automatic int tag_w(input int sets, input int line_bytes);
        return ADDR_W - $clog2(sets) - $clog2(line_bytes);
    endfunction
endpackage

// File: rtl/l1_cache_if.sv
// Bus bundle between the cache and its environment: the LC-3b word port on
// one side and the physical line port on the other. The slave modport is the
// cache; the master modport is the CPU plus physical memory.
interface l1_cache_if
    import cache_types::*;
#(
    parameter int LINE_BYTES = 16
);
    logic                      mem_read;
    logic                      mem_write;
    logic [1:0]                mem_byte_enable;
    lc3b_word                  mem_address;
    lc3b_word                  mem_wdata;
    lc3b_word                  mem_rdata;
    logic                      mem_resp;

    logic                      pmem_read;
    logic                      pmem_write;
    lc3b_word                  pmem_address;
    logic [LINE_BYTES*8-1:0]   pmem_wdata;
    logic [LINE_BYTES*8-1:0]   pmem_rdata;
    logic                      pmem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l1_cache_control.sv
// Cache controller FSM: decides hit/miss handling and drives the CPU
// response and the physical read/write handshakes. Handshake outputs are
// decoded from the state so an asynchronous reset drops them at once.
module cache_control
    import cache_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         hit,
    input  logic         victim_dirty,
    input  logic         pmem_resp,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic         fill_done,
    output cache_state_t state
);
    cache_state_t next_state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        next_state = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                    end else if (victim_dirty) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: rtl/l1_cache.sv
// Write-back, write-allocate, N-way set-associative L1 cache for the LC-3b
// memory port. Holds the tag/data/valid/dirty arrays, the per-set LRU ages,
// tag compare, victim choice and word/byte muxing; sequencing lives in
// cache_control.
module l1_cache
    import cache_types::*;
#(
    parameter int SETS       = 8,
    parameter int WAYS       = 2,
    parameter int LINE_BYTES = 16
) (
    input logic       clk,
    input logic       rst,
    l1_cache_if.slave bus
);
    localparam int OFFSET_W = offset_w(LINE_BYTES);
    localparam int INDEX_W  = index_w(SETS);
    localparam int TAG_W    = tag_w(SETS, LINE_BYTES);
    localparam int WORDS    = LINE_BYTES / 2;
    localparam int WSEL_W   = OFFSET_W - 1;
    localparam int AGE_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_W    = AGE_W;

    logic [TAG_W-1:0]   tags  [WAYS][SETS];
    lc3b_word           lines [WAYS][SETS][WORDS];
    logic               valid [SETS][WAYS];
    logic               dirty [SETS][WAYS];
    logic [AGE_W-1:0]   ages  [SETS][WAYS];

    logic [WSEL_W-1:0]  word_sel;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               req;
    logic               is_write;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim;
    logic               victim_dirty;
    logic               mem_resp;
    logic               fill_done;
    cache_state_t       state;

    // Miss context, frozen while the controller is away from IDLE so a
    // changing CPU address cannot redirect an in-flight line transfer.
    logic [INDEX_W-1:0] miss_index;
    logic [TAG_W-1:0]   miss_tag;
    logic [WAY_W-1:0]   miss_way;

    logic               unused_bits;

    assign word_sel    = bus.mem_address[OFFSET_W-1:1];
    assign req_index   = bus.mem_address[OFFSET_W +: INDEX_W];
    assign req_tag     = bus.mem_address[ADDR_W-1 -: TAG_W];
    assign req         = bus.mem_read | bus.mem_write;
    assign is_write    = bus.mem_write;
    assign unused_bits = bus.mem_address[0];

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_index][w] && (tags[w][req_index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-numbered invalid way, else the oldest way.
    always_comb begin
        logic found;
        victim = '0;
        found  = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_index][w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages[req_index][w] == AGE_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end

    assign victim_dirty = valid[req_index][victim] && dirty[req_index][victim];

    cache_control u_control (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .pmem_resp    (bus.pmem_resp),
        .mem_resp     (mem_resp),
        .pmem_read    (bus.pmem_read),
        .pmem_write   (bus.pmem_write),
        .fill_done    (fill_done),
        .state        (state)
    );

    assign bus.mem_resp  = mem_resp;
    assign bus.mem_rdata = lines[hit_way][req_index][word_sel];

    assign bus.pmem_address = (state == WRITEBACK)
        ? {tags[miss_way][miss_index], miss_index, {OFFSET_W{1'b0}}}
        : {miss_tag, miss_index, {OFFSET_W{1'b0}}};

    // Victim line flattened onto the physical write bus.
    always_comb begin
        bus.pmem_wdata = '0;
        for (int k = 0; k < WORDS; k++) begin
            bus.pmem_wdata[k*16 +: 16] = lines[miss_way][miss_index][k];
        end
    end

    // Capture the miss context on every IDLE cycle; it holds once we leave.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            miss_index <= req_index;
            miss_tag   <= req_tag;
            miss_way   <= victim;
        end
    end

    // Line status and LRU ages; reset invalidates everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    ages[s][w]  <= AGE_W'(WAYS - 1 - w);
                end
            end
        end else if (fill_done) begin
            valid[miss_index][miss_way] <= 1'b1;
            dirty[miss_index][miss_way] <= 1'b0;
        end else if (mem_resp) begin
            if (is_write && (bus.mem_byte_enable != 2'b00)) begin
                dirty[req_index][hit_way] <= 1'b1;
            end
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == hit_way) begin
                    ages[req_index][w] <= '0;
                end else if (ages[req_index][w] < ages[req_index][hit_way]) begin
                    ages[req_index][w] <= ages[req_index][w] + 1'b1;
                end
            end
        end
    end

    // Tag and data storage: line fills and byte-lane write hits.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tags[miss_way][miss_index] <= miss_tag;
            for (int k = 0; k < WORDS; k++) begin
                lines[miss_way][miss_index][k] <= bus.pmem_rdata[k*16 +: 16];
            end
        end else if (mem_resp && is_write) begin
            if (bus.mem_byte_enable[0]) begin
                lines[hit_way][req_index][word_sel][7:0] <= bus.mem_wdata[7:0];
            end
            if (bus.mem_byte_enable[1]) begin
                lines[hit_way][req_index][word_sel][15:8] <= bus.mem_wdata[15:8];
            end
        end
    end
endmodule
